// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types, widths and waveform shaper for note_synth
package synth_pkg;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam logic [1:0] WAVE_SQUARE = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;

    // ph is phase[31:15]: only the top 17 phase bits ever reach the waveform
    function automatic logic [SAMPLE_W-1:0] wave_shape(input logic [16:0] ph,
                                                       input logic [1:0]  sel);
        logic [SAMPLE_W-1:0] w;
        case (sel)
            WAVE_SAW: w = ph[16:1] ^ 16'h8000;
            WAVE_TRI: w = (ph[16] ? ~ph[15:0] : ph[15:0]) ^ 16'h8000;
            default:  w = ph[16] ? 16'h8001 : 16'h7fff;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/note_synth_counter.sv
// rtl/note_synth_counter.sv - free-running up counter with synchronous clear
module note_synth_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/note_synth.sv
// rtl/note_synth.sv - DDS tone generator with attack/release envelope and sample handshake
module note_synth
    import synth_pkg::*;
#(
    parameter int sample_div_p   = 250,
    parameter int attack_step_p  = 8,
    parameter int release_step_p = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         fstep_i,
    input  logic [1:0]          wave_sel_i,
    output logic [SAMPLE_W-1:0] data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overrun_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(sample_div_p);
    localparam logic [CNT_W-1:0]  TICK_LAST    = CNT_W'(sample_div_p - 1);
    localparam logic [GAIN_W:0]   ATTACK_STEP  = (GAIN_W + 1)'(attack_step_p);
    localparam logic [GAIN_W-1:0] RELEASE_STEP = GAIN_W'(release_step_p);
    localparam logic [GAIN_W-1:0] GAIN_MAX     = '1;

    logic [CNT_W-1:0] count;
    logic             tick;

    env_state_t        state_q, state_d, trans;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W:0]   gain_sum;
    logic [31:0]       phase_q, phase_d;
    logic [31:0]       fstep_l_q, fstep_l_d;

    logic                smp_vld_q;
    logic [SAMPLE_W-1:0] smp_wave_q;
    logic [GAIN_W-1:0]   smp_gain_q;
    logic signed [SAMPLE_W+GAIN_W-1:0] prod;

    logic [SAMPLE_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    assign tick = (count == TICK_LAST);

    note_synth_counter #(
        .WIDTH (CNT_W)
    ) u_tick_cnt (
        .clk_i   (clk_i),
        .clear_i (reset_i | tick),
        .en_i    (1'b1),
        .count_o (count)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            gain_q     <= '0;
            phase_q    <= '0;
            fstep_l_q  <= '0;
            smp_vld_q  <= 1'b0;
            smp_wave_q <= '0;
            smp_gain_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            phase_q    <= phase_d;
            fstep_l_q  <= fstep_l_d;
            smp_vld_q  <= tick;
            smp_wave_q <= wave_shape(phase_q[31:15], wave_sel_i);
            smp_gain_q <= gain_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // A new non-zero step retunes the note in every active state, attack included
    always_comb begin
        trans     = state_q;
        state_d   = state_q;
        gain_d    = gain_q;
        phase_d   = phase_q;
        fstep_l_d = fstep_l_q;
        gain_sum  = {1'b0, gain_q} + ATTACK_STEP;
        if (tick) begin
            if (fstep_i == '0) begin
                trans = (state_q == IDLE) ? IDLE : RELEASE;
            end else begin
                trans     = (state_q == SUSTAIN) ? SUSTAIN : ATTACK;
                fstep_l_d = fstep_i;
            end
            state_d = trans;
            case (trans)
                ATTACK: begin
                    gain_d = gain_sum[GAIN_W] ? GAIN_MAX : gain_sum[GAIN_W-1:0];
                    if (gain_d == GAIN_MAX) begin
                        state_d = SUSTAIN;
                    end
                end
                RELEASE: begin
                    gain_d = (gain_q > RELEASE_STEP) ? (gain_q - RELEASE_STEP) : '0;
                    if (gain_d == '0) begin
                        state_d = IDLE;
                    end
                end
                SUSTAIN: gain_d = gain_q;
                default: gain_d = '0;
            endcase
            phase_d = (state_d == IDLE) ? '0 : (phase_q + fstep_l_d);
        end
    end

    // Floor-rounded scaling: low 16 bits of (wave * gain) >>> 8
    always_comb begin
        prod      = $signed(smp_wave_q) * $signed({1'b0, smp_gain_q});
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (smp_vld_q) begin
            data_d  = SAMPLE_W'(prod >>> GAIN_W);
            valid_d = 1'b1;
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        data_o    = data_q;
        valid_o   = valid_q;
        overrun_o = overrun_q;
    end

endmodule

// File: tb/tb_note_synth.sv
// tb/tb_note_synth.sv - directed self-checking bench for note_synth
module tb_note_synth;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] fstep_i;
    logic [1:0]  wave_sel_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;
    logic        busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    int exp_att[8]  = '{8191, 16383, -24576, -32640, 32639, 32639, -32640, -32640};
    int exp_rel[4]  = '{24447, 16255, -8064, 0};
    int exp_saw[6]  = '{-8192, -8192, 0, 16320, -32640, -16320};
    int exp_tri[4]  = '{32639, -1, -32640, 0};

    note_synth #(
        .sample_div_p   (4),
        .attack_step_p  (64),
        .release_step_p (64)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .fstep_i    (fstep_i),
        .wave_sel_i (wave_sel_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic next_sample(output int d);
        bit found;
        found = 1'b0;
        d = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (valid_o) begin
                found = 1'b1;
                d = int'($signed(data_o));
            end
        end
        check("sample_seen", int'(found), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, int'(data_o), 0);
        check({tag, "_valid"}, int'(valid_o), 0);
        check({tag, "_overrun"}, int'(overrun_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d;
        int nv;
        reset_i    = 1'b1;
        fstep_i    = 32'h0;
        wave_sel_i = 2'd0;
        ready_i    = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", int'(dut.state_q), 0);
        reset_i = 1'b0;

        next_sample(d);
        check("rest_first", d, 0);
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (valid_o) begin
                nv++;
                check("rest_data", int'(data_o), 0);
            end
            check("rest_busy", int'(busy_o), 0);
        end
        check("rest_valid_count", nv, 4);

        fstep_i = 32'h4000_0000;
        for (int i = 0; i < 8; i++) begin
            next_sample(d);
            check($sformatf("attack_sq%0d", i), d, exp_att[i]);
        end
        check("sustain_busy", int'(busy_o), 1);

        fstep_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            next_sample(d);
            check($sformatf("release%0d", i), d, exp_rel[i]);
        end
        check("release_busy", int'(busy_o), 0);
        check("release_phase", int'(dut.phase_q), 0);
        check("release_state", int'(dut.state_q), 0);

        fstep_i    = 32'h4000_0000;
        wave_sel_i = 2'd1;
        for (int i = 0; i < 6; i++) begin
            next_sample(d);
            check($sformatf("saw%0d", i), d, exp_saw[i]);
        end
        wave_sel_i = 2'd2;
        for (int i = 0; i < 4; i++) begin
            next_sample(d);
            check($sformatf("tri%0d", i), d, exp_tri[i]);
        end

        wave_sel_i = 2'd1;
        ready_i    = 1'b0;
        repeat (9) @(negedge clk);
        check("ovr_flag", int'(overrun_o), 1);
        check("ovr_valid", int'(valid_o), 1);
        check("ovr_data", int'($signed(data_o)), 16320);
        ready_i = 1'b1;
        @(negedge clk);
        check("ovr_valid_drop", int'(valid_o), 0);
        check("ovr_sticky", int'(overrun_o), 1);
        next_sample(d);
        check("ovr_next", d, -32640);
        check("ovr_sticky2", int'(overrun_o), 1);

        reset_i    = 1'b1;
        wave_sel_i = 2'd0;
        @(negedge clk);
        reset_i = 1'b0;
        check("rst1_overrun", int'(overrun_o), 0);
        next_sample(d);
        check("retrig0", d, 8191);
        next_sample(d);
        check("retrig1", d, 16383);
        check("mid_gain", int'(dut.gain_q), 128);
        reset_i = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        check("mid_reset_state", int'(dut.state_q), 0);
        reset_i = 1'b0;
        next_sample(d);
        check("post_reset0", d, 8191);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
